// File: rtl/rou_pkg.sv
// rou_pkg: definitions shared by the rou message packer and the rou field
// decoder. It holds the command encodings, the byte-count width derivation
// and the bit offsets of each message field. The layout, LSB first, is
// cmd | tag | bytes | addr | data.
package rou_pkg;

   typedef enum logic [1:0] {
      CMD_ILL_00 = 2'b00,
      CMD_WRITE  = 2'b01,
      CMD_READ   = 2'b10,
      CMD_ILL_11 = 2'b11
   } rou_cmd_e;

   localparam int unsigned CMD_LSB = 0;
   localparam int unsigned CMD_W   = 2;
   localparam int unsigned TAG_LSB = CMD_LSB + CMD_W;

   // Width of the byte-count field for a given data width.
   function automatic int unsigned rou_bwid(input int unsigned dwid);
      case (dwid)
         512:     return 6;
         256:     return 5;
         128:     return 4;
         64:      return 3;
         default: return 2;
      endcase
   endfunction

   function automatic int unsigned rou_bytes_lsb(input int unsigned twid);
      return TAG_LSB + twid;
   endfunction

   function automatic int unsigned rou_addr_lsb(input int unsigned twid,
                                                input int unsigned bwid);
      return rou_bytes_lsb(twid) + bwid;
   endfunction

   function automatic int unsigned rou_data_lsb(input int unsigned twid,
                                                input int unsigned bwid,
                                                input int unsigned awid);
      return rou_addr_lsb(twid, bwid) + awid;
   endfunction

   function automatic logic rou_cmd_legal(input logic [1:0] cmd);
      return (cmd == CMD_WRITE) || (cmd == CMD_READ);
   endfunction

endpackage

// File: rtl/rou_tag_pool.sv
// rou_tag_pool: free pool of 2**TWID transaction tags.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   alloc           take the lowest free tag this cycle
//   alloc_tag       lowest-index free tag (from registered bitmap)
//   any_free        at least one tag is free
//   ret_vld/ret_tag tag return strobe and value
//   tags_busy       number of outstanding tags
//   err_tag         one-cycle pulse: returned tag was not outstanding
module rou_tag_pool #(
   parameter int unsigned TWID = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alloc,
   output logic [TWID-1:0] alloc_tag,
   output logic            any_free,
   input  logic            ret_vld,
   input  logic [TWID-1:0] ret_tag,
   output logic [TWID:0]   tags_busy,
   output logic            err_tag
);

   localparam int unsigned NTAG = 2 ** TWID;

   logic [NTAG-1:0] busy_q, busy_d;
   logic [TWID:0]   cnt_q, cnt_d;
   logic            err_tag_q, err_tag_d;
   logic            found;
   logic            ret_ok;

   // Lowest-index free tag, looked up in the bitmap as it stood at the
   // start of the cycle, so a same-cycle return is not visible yet.
   always_comb begin
      alloc_tag = '0;
      found     = 1'b0;
      for (int unsigned i = 0; i < NTAG; i++) begin
         if (!found && !busy_q[i]) begin
            alloc_tag = TWID'(i);
            found     = 1'b1;
         end
      end
   end

   assign any_free = found;

   // A return is only honoured for a tag busy at the start of the cycle.
   // Returning the tag being allocated right now therefore flags an error
   // and leaves the tag busy.
   assign ret_ok = ret_vld && busy_q[ret_tag];

   always_comb begin
      busy_d = busy_q;
      if (alloc) begin
         busy_d[alloc_tag] = 1'b1;
      end
      if (ret_ok) begin
         busy_d[ret_tag] = 1'b0;
      end
      cnt_d     = cnt_q + (TWID+1)'(alloc) - (TWID+1)'(ret_ok);
      err_tag_d = ret_vld && !ret_ok;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q    <= '0;
         cnt_q     <= '0;
         err_tag_q <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         err_tag_q <= err_tag_d;
      end
   end

   assign tags_busy = cnt_q;
   assign err_tag   = err_tag_q;

endmodule

// File: rtl/rou_msg_pack.sv
// rou_msg_pack: transmit-side message builder for the rou bus.
// A request is tagged from the rou_tag_pool, packed as
// {data, addr, bytes, tag, cmd} and queued in a 2-entry output FIFO.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_vld/req_rdy          request handshake
//   req_cmd/addr/data/bytes  request fields (cmd 01=WRITE, 10=READ)
//   msg_vld/msg_rdy/msg      output message handshake and payload
//   tag_ret_vld/tag_ret      tag return from the responder side
//   tags_busy                outstanding tag count
//   err_cmd                  one-cycle pulse: illegal cmd accepted and dropped
//   err_tag                  one-cycle pulse: returned tag was not outstanding
module rou_msg_pack
   import rou_pkg::*;
#(
   parameter int unsigned DWID = 128,
   parameter int unsigned AWID = 32,
   parameter int unsigned TWID = 5,
   parameter int unsigned BWID = rou_bwid(DWID),
   parameter int unsigned WID  = 2 + DWID + AWID + BWID + TWID
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_vld,
   output logic            req_rdy,
   input  logic [1:0]      req_cmd,
   input  logic [AWID-1:0] req_addr,
   input  logic [DWID-1:0] req_data,
   input  logic [BWID-1:0] req_bytes,
   output logic            msg_vld,
   input  logic            msg_rdy,
   output logic [WID-1:0]  msg,
   input  logic            tag_ret_vld,
   input  logic [TWID-1:0] tag_ret,
   output logic [TWID:0]   tags_busy,
   output logic            err_cmd,
   output logic            err_tag
);

   localparam int unsigned BYTES_LSB = rou_bytes_lsb(TWID);
   localparam int unsigned ADDR_LSB  = rou_addr_lsb(TWID, BWID);
   localparam int unsigned DATA_LSB  = rou_data_lsb(TWID, BWID, AWID);

   logic [1:0]      cnt_q, cnt_d;
   logic [WID-1:0]  head_q, head_d;
   logic [WID-1:0]  tail_q, tail_d;
   logic            err_cmd_q, err_cmd_d;

   logic            accept;
   logic            legal;
   logic            push;
   logic            pop;
   logic            any_free;
   logic [TWID-1:0] alloc_tag;
   logic [WID-1:0]  msg_new;

   // Ready depends only on registered FIFO occupancy and the tag bitmap.
   assign req_rdy = (cnt_q < 2'd2) && any_free;
   assign accept  = req_vld && req_rdy;
   assign legal   = rou_cmd_legal(req_cmd);
   assign push    = accept && legal;
   assign pop     = (cnt_q != 2'd0) && msg_rdy;

   rou_tag_pool #(
      .TWID (TWID)
   ) u_tag_pool (
      .clk       (clk),
      .rst       (rst),
      .alloc     (push),
      .alloc_tag (alloc_tag),
      .any_free  (any_free),
      .ret_vld   (tag_ret_vld),
      .ret_tag   (tag_ret),
      .tags_busy (tags_busy),
      .err_tag   (err_tag)
   );

   always_comb begin
      msg_new                        = '0;
      msg_new[CMD_LSB +: CMD_W]      = req_cmd;
      msg_new[TAG_LSB +: TWID]       = alloc_tag;
      msg_new[BYTES_LSB +: BWID]     = req_bytes;
      msg_new[ADDR_LSB +: AWID]      = req_addr;
      msg_new[DATA_LSB +: DWID]      = req_data;
   end

   // head_q is the visible entry; tail_q only holds a second message.
   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      cnt_d     = cnt_q;
      err_cmd_d = accept && !legal;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               head_d = msg_new;
            end else begin
               tail_d = msg_new;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            if (cnt_q == 2'd2) begin
               head_d = tail_q;
            end
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               head_d = msg_new;
            end else begin
               head_d = tail_q;
               tail_d = msg_new;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         err_cmd_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         err_cmd_q <= err_cmd_d;
      end
   end

   assign msg_vld = (cnt_q != 2'd0);
   assign msg     = head_q;
   assign err_cmd = err_cmd_q;

endmodule

// File: tb/tb_rou_msg_pack.sv
// tb_rou_msg_pack: directed self-checking bench for rou_msg_pack with
// DWID=128, AWID=32, TWID=5 (BWID=4, WID=171).
module tb_rou_msg_pack;

   logic           clk;
   logic           rst;
   logic           req_vld;
   logic           req_rdy;
   logic [1:0]     req_cmd;
   logic [31:0]    req_addr;
   logic [127:0]   req_data;
   logic [3:0]     req_bytes;
   logic           msg_vld;
   logic           msg_rdy;
   logic [170:0]   msg;
   logic           tag_ret_vld;
   logic [4:0]     tag_ret;
   logic [5:0]     tags_busy;
   logic           err_cmd;
   logic           err_tag;

   int errors = 0;
   int checks = 0;

   rou_msg_pack #(
      .DWID (128),
      .AWID (32),
      .TWID (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_vld     (req_vld),
      .req_rdy     (req_rdy),
      .req_cmd     (req_cmd),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_bytes   (req_bytes),
      .msg_vld     (msg_vld),
      .msg_rdy     (msg_rdy),
      .msg         (msg),
      .tag_ret_vld (tag_ret_vld),
      .tag_ret     (tag_ret),
      .tags_busy   (tags_busy),
      .err_cmd     (err_cmd),
      .err_tag     (err_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [170:0] mk(input logic [1:0] c, input logic [4:0] t,
                                       input logic [3:0] b, input logic [31:0] a,
                                       input logic [127:0] d);
      return {d, a, b, t, c};
   endfunction

   task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [1:0] c, input logic [31:0] a,
                          input logic [127:0] d, input logic [3:0] b);
      req_cmd   = c;
      req_addr  = a;
      req_data  = d;
      req_bytes = b;
   endtask

   task automatic ret(input logic [4:0] t);
      tag_ret_vld = 1'b1;
      tag_ret     = t;
      tick();
      tag_ret_vld = 1'b0;
   endtask

   logic [170:0] m0, m1, m2;

   initial begin
      rst = 1'b1;
      req_vld = 1'b0;
      msg_rdy = 1'b0;
      tag_ret_vld = 1'b0;
      tag_ret = '0;
      set_req(2'b00, '0, '0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_msg_vld", msg_vld, 0);
      chk("rst_msg", msg, 0);
      chk("rst_tags_busy", tags_busy, 0);
      chk("rst_req_rdy", req_rdy, 1);
      chk("rst_err_cmd", err_cmd, 0);
      chk("rst_err_tag", err_tag, 0);

      // Single READ
      msg_rdy = 1'b1;
      set_req(2'b10, 32'h0000_1000, '0, 4'd4);
      req_vld = 1'b1;
      tick();
      req_vld = 1'b0;
      chk("rd_msg_vld", msg_vld, 1);
      chk("rd_msg", msg, mk(2'b10, 5'd0, 4'd4, 32'h1000, '0));
      chk("rd_cmd_field", msg[1:0], 2'b10);
      chk("rd_tag_field", msg[6:2], 0);
      chk("rd_bytes_field", msg[10:7], 4);
      chk("rd_addr_field", msg[42:11], 32'h1000);
      chk("rd_data_field", msg[170:43], 0);
      chk("rd_tags_busy", tags_busy, 1);
      tick();
      chk("rd_drained", msg_vld, 0);
      ret(5'd0);
      chk("rd_ret_busy", tags_busy, 0);
      chk("rd_ret_err", err_tag, 0);

      // Back-pressure: three WRITEs with msg_rdy low
      msg_rdy = 1'b0;
      m0 = mk(2'b01, 5'd0, 4'd1, 32'hA0, 128'hD0);
      m1 = mk(2'b01, 5'd1, 4'd2, 32'hA1, 128'hD1);
      m2 = mk(2'b01, 5'd2, 4'd3, 32'hA2, 128'hD2);
      set_req(2'b01, 32'hA0, 128'hD0, 4'd1);
      req_vld = 1'b1;
      tick();
      chk("bp_first", msg, m0);
      set_req(2'b01, 32'hA1, 128'hD1, 4'd2);
      tick();
      chk("bp_full_rdy", req_rdy, 0);
      chk("bp_busy2", tags_busy, 2);
      set_req(2'b01, 32'hA2, 128'hD2, 4'd3);
      tick();
      chk("bp_hold_msg", msg, m0);
      chk("bp_hold_busy", tags_busy, 2);
      msg_rdy = 1'b1;
      tick();
      chk("bp_drain1", msg, m1);
      tick();
      chk("bp_drain2", msg, m2);
      chk("bp_drain2_vld", msg_vld, 1);
      chk("bp_busy3", tags_busy, 3);
      req_vld = 1'b0;
      tick();
      chk("bp_empty", msg_vld, 0);
      for (int i = 0; i < 3; i++) ret(5'(i));
      chk("bp_ret_busy", tags_busy, 0);

      // Exhaust the pool
      req_vld = 1'b1;
      for (int i = 0; i < 32; i++) begin
         set_req(2'b01, 32'(i), 128'(i), 4'd0);
         tick();
      end
      req_vld = 1'b0;
      chk("full_busy", tags_busy, 32);
      chk("full_rdy", req_rdy, 0);
      chk("full_last_tag", msg[6:2], 31);
      tick();
      ret(5'd7);
      chk("full_ret_rdy", req_rdy, 1);
      chk("full_ret_busy", tags_busy, 31);
      set_req(2'b10, 32'h77, '0, 4'd1);
      req_vld = 1'b1;
      tick();
      req_vld = 1'b0;
      chk("full_realloc_tag", msg[6:2], 7);
      chk("full_realloc_busy", tags_busy, 32);
      tick();
      for (int i = 0; i < 32; i++) ret(5'(i));
      chk("full_ret_all", tags_busy, 0);
      chk("full_ret_all_err", err_tag, 0);

      // Same-cycle return and allocate
      req_vld = 1'b1;
      set_req(2'b01, 32'h10, 128'h1, 4'd2);
      repeat (6) tick();
      req_vld = 1'b0;
      tick();
      chk("sc_busy6", tags_busy, 6);
      req_vld = 1'b1;
      tag_ret_vld = 1'b1;
      tag_ret = 5'd3;
      tick();
      tag_ret_vld = 1'b0;
      chk("sc_tag6", msg[6:2], 6);
      chk("sc_busy", tags_busy, 6);
      chk("sc_no_err", err_tag, 0);
      tick();
      req_vld = 1'b0;
      chk("sc_tag3_next", msg[6:2], 3);
      chk("sc_busy7", tags_busy, 7);
      tick();
      for (int i = 0; i < 7; i++) ret(5'(i));
      chk("sc_ret_all", tags_busy, 0);

      // Return of a free tag
      ret(5'd12);
      chk("ft_err_tag", err_tag, 1);
      chk("ft_busy", tags_busy, 0);
      tick();
      chk("ft_err_tag_clr", err_tag, 0);

      // Illegal commands
      set_req(2'b11, 32'h55, 128'h5, 4'd1);
      req_vld = 1'b1;
      chk("ill_rdy", req_rdy, 1);
      tick();
      req_vld = 1'b0;
      chk("ill11_err_cmd", err_cmd, 1);
      chk("ill11_no_msg", msg_vld, 0);
      chk("ill11_busy", tags_busy, 0);
      tick();
      chk("ill11_err_clr", err_cmd, 0);
      set_req(2'b00, 32'h56, 128'h6, 4'd1);
      req_vld = 1'b1;
      tick();
      req_vld = 1'b0;
      chk("ill00_err_cmd", err_cmd, 1);
      chk("ill00_no_msg", msg_vld, 0);

      // Return of the tag being allocated in the same cycle
      set_req(2'b10, 32'h99, '0, 4'd5);
      req_vld = 1'b1;
      tag_ret_vld = 1'b1;
      tag_ret = 5'd0;
      tick();
      req_vld = 1'b0;
      tag_ret_vld = 1'b0;
      chk("sa_err_tag", err_tag, 1);
      chk("sa_busy", tags_busy, 1);
      chk("sa_tag", msg[6:2], 0);
      tick();
      ret(5'd0);
      chk("sa_ret_busy", tags_busy, 0);
      chk("sa_ret_err", err_tag, 0);

      // Async reset with queued messages and busy tags
      set_req(2'b01, 32'hC0, 128'hC, 4'd1);
      req_vld = 1'b1;
      repeat (2) tick();
      req_vld = 1'b0;
      tick();
      msg_rdy = 1'b0;
      req_vld = 1'b1;
      repeat (2) tick();
      req_vld = 1'b0;
      chk("ar_pre_vld", msg_vld, 1);
      chk("ar_pre_busy", tags_busy, 4);
      chk("ar_pre_rdy", req_rdy, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_msg_vld", msg_vld, 0);
      chk("ar_busy", tags_busy, 0);
      chk("ar_msg", msg, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      msg_rdy = 1'b1;
      set_req(2'b10, 32'hE0, '0, 4'd2);
      req_vld = 1'b1;
      tick();
      req_vld = 1'b0;
      chk("ar_post_tag", msg[6:2], 0);
      chk("ar_post_msg", msg, mk(2'b10, 5'd0, 4'd2, 32'hE0, '0));
      ret(5'd2);
      chk("ar_forgot_err", err_tag, 1);
      chk("ar_forgot_busy", tags_busy, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rou_msg_pack.md
Name: rou_msg_pack

Overview:
- Transmit-side message builder for the rou bus.
- Accepts request fields (cmd, addr, data, byte-count), assigns a transaction tag from an internal free pool, packs the fields into a single WID-bit message, and presents it through a 2-entry output buffer with valid/ready handshake.
- Tags are recycled when the responder side returns them.
- Message layout matches the rou field decoder, so a packed message splits back into identical fields.

Parameters:
- DWID, 128, data field width.
- AWID, 32, address field width.
- TWID, 5, tag field width; pool holds 2**TWID tags.
- BWID, derived: 6 if DWID==512, 5 if 256, 4 if 128, 3 if 64, else 2; byte-count field width.
- WID, 2+DWID+AWID+BWID+TWID, message width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_vld  input  1  request valid.
- req_rdy  output  1  request accepted when req_vld && req_rdy.
- req_cmd  input  2  01=WRITE, 10=READ, 00/11 illegal.
- req_addr  input  AWID  address.
- req_data  input  DWID  write data (packed as-is for READ).
- req_bytes  input  BWID  byte count.
- msg_vld  output  1  output message valid.
- msg_rdy  input  1  downstream ready.
- msg  output  WID  packed message.
- tag_ret_vld  input  1  tag return strobe.
- tag_ret  input  TWID  tag being returned.
- tags_busy  output  TWID+1  number of outstanding tags.
- err_cmd  output  1  one-cycle pulse: illegal cmd accepted and dropped.
- err_tag  output  1  one-cycle pulse: returned tag was not outstanding.

Behaviour:
- Packing: msg = {data, addr, bytes, tag, cmd}, with cmd in bits [1:0] and data in the MSBs.
- Reset (async, rst=1) clears:
  - output FIFO: count=0, msg_vld=0, msg=0;
  - tag bitmap: all free, tags_busy=0;
  - err_cmd=0, err_tag=0.
  - Outstanding tags are forgotten; a later return of one of them raises err_tag.
- req_rdy = (fifo_count<2) && (any tag free). It depends only on registered state, never on req_vld or msg_rdy.
- Illegal cmd (00 or 11):
  - req_rdy for such a request follows the same rule as a legal one;
  - on handshake, nothing is pushed and no tag is consumed;
  - err_cmd pulses the next cycle.
- Legal accept:
  - allocate the lowest-index free tag from the bitmap state at the start of the cycle;
  - mark it busy;
  - push the packed message.
  - Latency: msg_vld rises the cycle after the accept; the message appears in the same cycle it is written if the FIFO was empty.
- Output FIFO: 2 entries, in-order; msg/msg_vld are driven from the head register.
  - Pop when msg_vld && msg_rdy.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - msg holds stable while msg_vld && !msg_rdy.
- Tag return when tag_ret_vld:
  - if the tag is busy: free it at the clock edge;
  - if it is free: err_tag pulses the next cycle and the bitmap is unchanged.
  - A tag returned in the same cycle as an allocation cannot be allocated that cycle; it is available the next cycle.
  - Returning the very tag being allocated this cycle counts as a return of a free tag: err_tag pulses and the tag becomes busy.
- tags_busy is updated each cycle: +1 on legal accept, -1 on valid return, net 0 when both occur.
  - Range 0..2**TWID.
  - When it reaches 2**TWID, req_rdy=0 until a return.

Decomposition:
- Shared package rou_pkg holds:
  - cmd encodings CMD_WRITE=2'b01, CMD_READ=2'b10;
  - the BWID derivation function;
  - field offset constants, shared with the decoder.
- Natural sub-module: rou_tag_pool, containing the bitmap, lowest-free priority encoder, busy counter and error detection.
- FIFO and packing stay in rou_msg_pack.

Test Plan:
- Reset, then one READ with addr=0x1000, bytes=4, data=0, msg_rdy=1 -> one cycle later msg_vld=1, msg[1:0]=10, tag=0, addr field=0x1000; tags_busy=1; decoder fields round-trip exactly.
- msg_rdy=0, issue 3 WRITEs -> first two accepted with tags 0 and 1; req_rdy=0 on the third; msg holds tag 0 stable; raise msg_rdy -> messages drain in order 0, 1, then the third accepts with tag 2.
- Allocate all 32 tags (TWID=5) -> tags_busy=32, req_rdy=0. Return tag 7 -> next cycle req_rdy=1; the next request gets tag 7.
- Same-cycle return of tag 3 and a new accept while tags 0-5 are busy -> new request gets tag 6; tags_busy unchanged; tag 3 is free next cycle.
- Return of free tag 12 -> err_tag pulses for exactly 1 cycle; tags_busy unchanged. Request with cmd=11 -> err_cmd pulses, no msg_vld, no tag consumed.
- Assert rst while 2 messages are queued and 4 tags are busy -> msg_vld=0 and tags_busy=0 immediately (async). After release, the next request gets tag 0.
